// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
package uart_pkg;

  localparam int unsigned DEFAULT_SAMPLE_RATE = 16;
  localparam int unsigned DEFAULT_DATA_BITS   = 8;
  localparam int unsigned MAX_DATA_BITS       = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // XOR-reduction of a zero-extended data word.
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: start-edge detect, mid-bit sampling, LSB-first
// assembly, parity and framing checks.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int unsigned SAMPLE_RATE = DEFAULT_SAMPLE_RATE,
  parameter bit          PARITY_EN   = 1'b0,
  parameter bit          PARITY_ODD  = 1'b0
) (
  input  logic                 Clock,
  input  logic                 ClearN,
  input  logic                 SampleTick,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] DataOut,
  output logic                 DataValid,
  output logic                 ParityError,
  output logic                 FrameError,
  output logic                 Busy
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_RATE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(SAMPLE_RATE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(SAMPLE_RATE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;
  logic rx_s_d;

  rx_state_t            state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [IDX_W-1:0]     bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic                 par_err, par_err_next;
  logic [DATA_BITS-1:0] data_out_next;
  logic                 dv_next;
  logic                 perr_next;
  logic                 ferr_next;
  logic                 busy_next;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (Clock),
    .rst_n (ClearN),
    .d     (Rx),
    .q     (rx_s)
  );

  always_ff @(posedge Clock) begin
    if (!ClearN) begin
      rx_s_d      <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      par_err     <= 1'b0;
      DataOut     <= '0;
      DataValid   <= 1'b0;
      ParityError <= 1'b0;
      FrameError  <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      rx_s_d      <= rx_s;
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      shreg       <= shreg_next;
      par_err     <= par_err_next;
      DataOut     <= data_out_next;
      DataValid   <= dv_next;
      ParityError <= perr_next;
      FrameError  <= ferr_next;
      Busy        <= busy_next;
    end
  end

  // Next-state and output logic; every sample point is gated by SampleTick.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    bit_idx_next  = bit_idx;
    shreg_next    = shreg;
    par_err_next  = par_err;
    data_out_next = DataOut;
    dv_next       = 1'b0;
    perr_next     = ParityError;
    ferr_next     = FrameError;

    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s && rx_s_d) begin
          state_next = START;
        end
      end

      START: begin
        if (SampleTick) begin
          if (cnt == CNT_MID) begin
            cnt_next     = '0;
            bit_idx_next = '0;
            par_err_next = 1'b0;
            state_next   = rx_s ? IDLE : DATA;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end

      DATA: begin
        if (SampleTick) begin
          if (cnt == CNT_END) begin
            cnt_next     = '0;
            shreg_next   = {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx_next = bit_idx + IDX_W'(1);
            if (bit_idx == IDX_LAST) begin
              state_next = PARITY_EN ? PARITY : STOP;
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end

      PARITY: begin
        if (SampleTick) begin
          if (cnt == CNT_END) begin
            cnt_next     = '0;
            par_err_next = parity_of(MAX_DATA_BITS'(shreg)) ^ rx_s ^ 1'(PARITY_ODD);
            state_next   = STOP;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end

      STOP: begin
        if (SampleTick) begin
          if (cnt == CNT_END) begin
            // Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
            cnt_next      = '0;
            state_next    = IDLE;
            dv_next       = 1'b1;
            data_out_next = shreg;
            ferr_next     = ~rx_s;
            perr_next     = PARITY_EN ? par_err : 1'b0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule
